// File: rtl/spi_pkg.sv
// -----------------------------------------------------------------------------
// spi_pkg
// Shared definitions for the SPI master/slave blocks.
//   state_t       : frame state (idle / shifting)
//   spi_cpol()    : clock polarity bit of an SPI mode number (0..3)
//   spi_cpha()    : clock phase bit of an SPI mode number (0..3)
//   SPI_MIN_SYNC  : smallest synchronizer depth the blocks will build
// -----------------------------------------------------------------------------
package spi_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    localparam int SPI_MIN_SYNC = 2;

    // Mode bit 1 is the sclk idle level.
    function automatic logic spi_cpol(input int mode);
        return mode[1];
    endfunction

    // Mode bit 0 selects sampling on the trailing (1) or leading (0) edge.
    function automatic logic spi_cpha(input int mode);
        return mode[0];
    endfunction

endpackage

// File: rtl/spi_sync.sv
// -----------------------------------------------------------------------------
// spi_sync
// Single-bit multi-flop synchronizer for one asynchronous SPI pin.
// Parameters:
//   SYNC_STAGES : flop depth (values below SPI_MIN_SYNC are raised to it)
//   RST_VAL     : value all flops take during reset
// Ports:
//   clk, rst : system clock, asynchronous active-high reset
//   d        : asynchronous input
//   q        : synchronized output
// -----------------------------------------------------------------------------
module spi_sync
    import spi_pkg::*;
#(
    parameter int   SYNC_STAGES = 2,
    parameter logic RST_VAL     = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    localparam int DEPTH = (SYNC_STAGES < SPI_MIN_SYNC) ? SPI_MIN_SYNC : SYNC_STAGES;

    logic [DEPTH-1:0] sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= {DEPTH{RST_VAL}};
        end else begin
            sync_q <= {sync_q[DEPTH-2:0], d};
        end
    end

    assign q = sync_q[DEPTH-1];

endmodule

// File: rtl/spi_slave.sv
// -----------------------------------------------------------------------------
// spi_slave
// SPI slave, all SPI pins oversampled in the clk domain (clk >= 8x sclk).
// Parameters:
//   SPI_MODE    : 0..3, bit1 = CPOL, bit0 = CPHA
//   DATA_WIDTH  : bits per word, MSB first
//   SYNC_STAGES : synchronizer depth for sclk / ss_n / mosi
// Ports:
//   clk, rst            : system clock, asynchronous active-high reset
//   sclk, ss_n, mosi    : SPI bus from the master (asynchronous)
//   miso, miso_oe       : serial data to the master, pad output enable
//   tx_data/valid/ready : next-word transmit handshake (one-word buffer)
//   rx_data, rx_valid   : last received word, 1-cycle strobe per word
//   busy                : slave is selected
//   underrun            : 1-cycle pulse, a word was needed but none buffered
//   frame_err           : 1-cycle pulse, frame ended mid-word
// -----------------------------------------------------------------------------
module spi_slave
    import spi_pkg::*;
#(
    parameter int SPI_MODE    = 0,
    parameter int DATA_WIDTH  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sclk,
    input  logic                  ss_n,
    input  logic                  mosi,
    output logic                  miso,
    output logic                  miso_oe,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  busy,
    output logic                  underrun,
    output logic                  frame_err
);

    localparam logic            CPOL     = spi_cpol(SPI_MODE);
    localparam logic            CPHA     = spi_cpha(SPI_MODE);
    localparam int              CNT_W    = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    // ---- stage p0: synchronized pins --------------------------------------
    logic sclk_p0;
    logic ss_n_p0;
    logic mosi_p0;

    spi_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(CPOL)) u_sync_sclk (
        .clk (clk),
        .rst (rst),
        .d   (sclk),
        .q   (sclk_p0)
    );

    spi_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ss_n (
        .clk (clk),
        .rst (rst),
        .d   (ss_n),
        .q   (ss_n_p0)
    );

    spi_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
        .clk (clk),
        .rst (rst),
        .d   (mosi),
        .q   (mosi_p0)
    );

    // ---- stage p1: one-cycle-old copies for edge detection ----------------
    logic sclk_p1;
    logic ss_n_p1;
    logic mosi_p1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_p1 <= CPOL;
            ss_n_p1 <= 1'b1;
            mosi_p1 <= 1'b0;
        end else begin
            sclk_p1 <= sclk_p0;
            ss_n_p1 <= ss_n_p0;
            mosi_p1 <= mosi_p0;
        end
    end

    // ---- edge / event decode ----------------------------------------------
    logic lead_edge;
    logic trail_edge;
    logic ss_fall;
    logic ss_rise;

    // Leading edge leaves the idle level, trailing edge returns to it.
    assign lead_edge  = (sclk_p1 == CPOL) && (sclk_p0 != CPOL);
    assign trail_edge = (sclk_p1 != CPOL) && (sclk_p0 == CPOL);
    assign ss_fall    =  ss_n_p1 && !ss_n_p0;
    assign ss_rise    = !ss_n_p1 &&  ss_n_p0;

    state_t                  state;
    logic [DATA_WIDTH-1:0]   tx_buf;
    logic                    tx_buf_full;
    logic [DATA_WIDTH-1:0]   tx_shift;
    logic [DATA_WIDTH-1:0]   rx_shift;
    logic [CNT_W-1:0]        bit_cnt;
    logic                    word_end;

    logic                    in_shift;
    logic                    sample_evt;
    logic                    shift_edge;
    logic                    load_evt;
    logic                    shift_evt;
    logic                    tx_accept;
    logic [DATA_WIDTH:0]     rx_ext;
    logic [DATA_WIDTH-1:0]   rx_next;

    // sclk edges only count while selected; the deselect cycle wins over them.
    assign in_shift   = (state == ST_SHIFT) && !ss_rise;
    assign sample_evt = in_shift && (CPHA ? trail_edge : lead_edge);
    assign shift_edge = in_shift && (CPHA ? lead_edge  : trail_edge);

    // CPHA=0: the first bit must be on miso before the first sample, so the
    // buffer is loaded at select time and again on the shift edge right after
    // each word's last sample. CPHA=1: the first shift edge of every word
    // (bit count still zero) is the load point.
    assign load_evt = CPHA ? (shift_edge && (bit_cnt == '0))
                           : (((state == ST_IDLE) && ss_fall) || (shift_edge && word_end));

    // A shift edge that performs a load does not also shift.
    assign shift_evt = shift_edge && !load_evt;

    assign tx_accept = tx_valid && !tx_buf_full;
    assign tx_ready  = !tx_buf_full;

    assign rx_ext  = {rx_shift, mosi_p1};
    assign rx_next = rx_ext[DATA_WIDTH-1:0];

    // ---- stage p2: frame FSM, shifters and registered outputs -------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            busy        <= 1'b0;
            tx_buf      <= '0;
            tx_buf_full <= 1'b0;
            tx_shift    <= '0;
            rx_shift    <= '0;
            bit_cnt     <= '0;
            word_end    <= 1'b0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            underrun    <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            rx_valid  <= 1'b0;
            underrun  <= 1'b0;
            frame_err <= 1'b0;

            // Load takes the old buffer contents first; a word accepted in the
            // same cycle refills the freshly emptied buffer.
            if (load_evt) begin
                tx_shift <= tx_buf_full ? tx_buf : '0;
                underrun <= !tx_buf_full;
            end else if (shift_evt) begin
                tx_shift <= tx_shift << 1;
            end

            if (tx_accept) begin
                tx_buf      <= tx_data;
                tx_buf_full <= 1'b1;
            end else if (load_evt) begin
                tx_buf_full <= 1'b0;
            end

            case (state)
                ST_IDLE: begin
                    if (ss_fall) begin
                        state    <= ST_SHIFT;
                        busy     <= 1'b1;
                        bit_cnt  <= '0;
                        word_end <= 1'b0;
                        rx_shift <= '0;
                    end
                end
                ST_SHIFT: begin
                    if (ss_rise) begin
                        state     <= ST_IDLE;
                        busy      <= 1'b0;
                        frame_err <= (bit_cnt != '0);
                        bit_cnt   <= '0;
                        word_end  <= 1'b0;
                        rx_shift  <= '0;
                        tx_shift  <= '0;
                    end else begin
                        if (sample_evt) begin
                            rx_shift <= rx_next;
                            if (bit_cnt == LAST_BIT) begin
                                rx_data  <= rx_next;
                                rx_valid <= 1'b1;
                                bit_cnt  <= '0;
                                word_end <= 1'b1;
                            end else begin
                                bit_cnt <= bit_cnt + CNT_W'(1);
                            end
                        end
                        if (shift_edge) begin
                            word_end <= 1'b0;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign miso    = busy & tx_shift[DATA_WIDTH-1];
    assign miso_oe = busy;

endmodule

// File: tb/tb_spi_slave.sv
// -----------------------------------------------------------------------------
// tb_spi_slave
// One spi_slave per SPI mode (0..3), each with its own bus; a behavioural SPI
// master drives one instance at a time and records miso. Expected results come
// from a table of single-word exchanges, hand-written multi-word / abort /
// reset sequences, and a randomized run checked against a word-level model.
// -----------------------------------------------------------------------------
module tb_spi_slave;

    localparam int HALF = 80;   // sclk half period: 8 clk cycles

    typedef struct {
        int         mode;
        logic [7:0] mosi_w;
        logic [7:0] tx_w;
        bit         preload;
        logic [7:0] exp_rx;
        logic [7:0] exp_miso;
        int         exp_und;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       sclk [4];
    logic       ss_n [4];
    logic       mosi [4];
    logic       miso [4];
    logic       miso_oe [4];
    logic [7:0] tx_data [4];
    logic       tx_valid [4];
    logic       tx_ready [4];
    logic [7:0] rx_data [4];
    logic       rx_valid [4];
    logic       busy [4];
    logic       underrun [4];
    logic       frame_err [4];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        spi_slave #(.SPI_MODE(g), .DATA_WIDTH(8), .SYNC_STAGES(2)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .sclk      (sclk[g]),
            .ss_n      (ss_n[g]),
            .mosi      (mosi[g]),
            .miso      (miso[g]),
            .miso_oe   (miso_oe[g]),
            .tx_data   (tx_data[g]),
            .tx_valid  (tx_valid[g]),
            .tx_ready  (tx_ready[g]),
            .rx_data   (rx_data[g]),
            .rx_valid  (rx_valid[g]),
            .busy      (busy[g]),
            .underrun  (underrun[g]),
            .frame_err (frame_err[g])
        );
    end

    // Pulse counters and a log of every word presented with rx_valid.
    int         rxv_cnt [4];
    int         und_cnt [4];
    int         fe_cnt [4];
    logic [7:0] rx_log [4][64];

    always @(posedge clk) begin
        for (int m = 0; m < 4; m++) begin
            if (rx_valid[m]) begin
                rx_log[m][rxv_cnt[m] % 64] <= rx_data[m];
                rxv_cnt[m] <= rxv_cnt[m] + 1;
            end
            if (underrun[m])  und_cnt[m] <= und_cnt[m] + 1;
            if (frame_err[m]) fe_cnt[m]  <= fe_cnt[m] + 1;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Push one word through the tx handshake, waiting (bounded) for room.
    task automatic load_tx(input int m, input logic [7:0] d);
        int t;
        t = 0;
        @(posedge clk); #1;
        while (!tx_ready[m] && t < 5000) begin
            @(posedge clk); #1;
            t++;
        end
        if (!tx_ready[m]) begin
            n_checks++;
            n_fail++;
            $display("FAIL tx_ready timeout: mode %0d got 0, expected 1", m);
        end else begin
            tx_data[m]  = d;
            tx_valid[m] = 1'b1;
            @(posedge clk); #1;
            tx_valid[m] = 1'b0;
        end
    endtask

    // Behavioural master: selects instance m, clocks nbits MSB first from
    // mosi_v, captures miso at the master's sampling point of each bit.
    task automatic spi_frame(input int m, input int nbits, input logic [63:0] mosi_v,
                             input bit raise_ss, output logic [63:0] miso_v);
        bit cpol;
        bit cpha;
        cpol   = m[1];
        cpha   = m[0];
        miso_v = '0;
        sclk[m] = cpol;
        ss_n[m] = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            if (!cpha) begin
                mosi[m] = mosi_v[nbits-1-i];
                #HALF;
                miso_v  = {miso_v[62:0], miso[m]};
                sclk[m] = ~cpol;
                #HALF;
                sclk[m] = cpol;
            end else begin
                #HALF;
                sclk[m] = ~cpol;
                mosi[m] = mosi_v[nbits-1-i];
                #HALF;
                miso_v  = {miso_v[62:0], miso[m]};
                sclk[m] = cpol;
            end
        end
        #HALF;
        if (raise_ss) begin
            ss_n[m] = 1'b1;
            #(2*HALF);
        end
    endtask

    // Word-level model: a frame of n words needs n loads (CPHA=1) or n+1
    // loads (CPHA=0: one at select, one after every word). Loads consume the
    // supplied words in order; any load beyond them sends zeros and counts
    // as an underrun.
    task automatic run_random(input int it);
        int          m, n, nl, k, rx0, und0, fe0;
        logic [7:0]  mw [3];
        logic [7:0]  sw [4];
        logic [63:0] mosi_v;
        logic [63:0] miso_v;
        logic [7:0]  exp_w;
        m  = int'($urandom_range(0, 3));
        n  = int'($urandom_range(1, 3));
        nl = (m % 2 == 1) ? n : n + 1;
        k  = int'($urandom_range(0, nl));
        mosi_v = '0;
        for (int w = 0; w < n; w++) begin
            mw[w]  = 8'($urandom);
            mosi_v = {mosi_v[55:0], mw[w]};
        end
        for (int j = 0; j < 4; j++) sw[j] = 8'($urandom);
        rx0  = rxv_cnt[m];
        und0 = und_cnt[m];
        fe0  = fe_cnt[m];
        if (k > 0) load_tx(m, sw[0]);
        fork
            begin
                for (int j = 1; j < k; j++) load_tx(m, sw[j]);
            end
            spi_frame(m, 8*n, mosi_v, 1'b1, miso_v);
        join
        repeat (4) @(posedge clk);
        #1;
        for (int w = 0; w < n; w++) begin
            exp_w = (w < k) ? sw[w] : 8'h00;
            check($sformatf("rand%0d m%0d miso word%0d", it, m, w), 64'(miso_v[8*(n-1-w) +: 8]), 64'(exp_w));
            check($sformatf("rand%0d m%0d rx word%0d", it, m, w), 64'(rx_log[m][(rx0+w) % 64]), 64'(mw[w]));
        end
        check($sformatf("rand%0d rx_valid count", it), 64'(rxv_cnt[m] - rx0), 64'(n));
        check($sformatf("rand%0d underrun count", it), 64'(und_cnt[m] - und0), 64'(nl - k));
        check($sformatf("rand%0d frame_err count", it), 64'(fe_cnt[m] - fe0), 64'(0));
        check($sformatf("rand%0d busy after", it), 64'(busy[m]), 64'(0));
        check($sformatf("rand%0d tx_ready after", it), 64'(tx_ready[m]), 64'(1));
    endtask

    initial begin
        #20000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vecs [8];
        vec_t        v;
        logic [63:0] miso_v;
        int          rx0, und0, fe0;

        // mode, mosi, tx, preload, exp rx, exp miso, exp underruns
        vecs[0] = '{0, 8'h3C, 8'hA5, 1'b1, 8'h3C, 8'hA5, 1};
        vecs[1] = '{1, 8'h3C, 8'hA5, 1'b1, 8'h3C, 8'hA5, 0};
        vecs[2] = '{2, 8'h3C, 8'hA5, 1'b1, 8'h3C, 8'hA5, 1};
        vecs[3] = '{3, 8'h3C, 8'hA5, 1'b1, 8'h3C, 8'hA5, 0};
        vecs[4] = '{1, 8'h5A, 8'h00, 1'b0, 8'h5A, 8'h00, 1};
        vecs[5] = '{0, 8'hC7, 8'h00, 1'b0, 8'hC7, 8'h00, 2};
        vecs[6] = '{2, 8'hFF, 8'h00, 1'b1, 8'hFF, 8'h00, 1};
        vecs[7] = '{3, 8'h00, 8'hFF, 1'b1, 8'h00, 8'hFF, 0};

        rst = 1'b1;
        for (int m = 0; m < 4; m++) begin
            sclk[m]     = m[1];
            ss_n[m]     = 1'b1;
            mosi[m]     = 1'b0;
            tx_valid[m] = 1'b0;
            tx_data[m]  = 8'h00;
        end
        #1;
        repeat (5) @(posedge clk);
        #1;
        for (int m = 0; m < 4; m++) begin
            check($sformatf("reset m%0d tx_ready", m), 64'(tx_ready[m]), 64'(1));
            check($sformatf("reset m%0d busy", m),     64'(busy[m]),     64'(0));
            check($sformatf("reset m%0d miso", m),     64'(miso[m]),     64'(0));
            check($sformatf("reset m%0d miso_oe", m),  64'(miso_oe[m]),  64'(0));
            check($sformatf("reset m%0d rx_data", m),  64'(rx_data[m]),  64'(0));
        end
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;

        // Single-word exchanges in every mode.
        for (int i = 0; i < 8; i++) begin
            v    = vecs[i];
            rx0  = rxv_cnt[v.mode];
            und0 = und_cnt[v.mode];
            fe0  = fe_cnt[v.mode];
            if (v.preload) load_tx(v.mode, v.tx_w);
            spi_frame(v.mode, 8, 64'(v.mosi_w), 1'b1, miso_v);
            repeat (4) @(posedge clk);
            #1;
            check($sformatf("vec%0d rx_data", i),  64'(rx_data[v.mode]), 64'(v.exp_rx));
            check($sformatf("vec%0d rx_valid count", i), 64'(rxv_cnt[v.mode] - rx0), 64'(1));
            check($sformatf("vec%0d miso", i),     64'(miso_v[7:0]), 64'(v.exp_miso));
            check($sformatf("vec%0d underrun count", i), 64'(und_cnt[v.mode] - und0), 64'(v.exp_und));
            check($sformatf("vec%0d frame_err count", i), 64'(fe_cnt[v.mode] - fe0), 64'(0));
        end

        // Back-to-back words, second tx word supplied while the first shifts.
        rx0  = rxv_cnt[1];
        und0 = und_cnt[1];
        load_tx(1, 8'h81);
        fork
            load_tx(1, 8'h42);
            spi_frame(1, 16, 64'h1122, 1'b1, miso_v);
        join
        repeat (4) @(posedge clk);
        #1;
        check("b2b miso word0", 64'(miso_v[15:8]), 64'h81);
        check("b2b miso word1", 64'(miso_v[7:0]),  64'h42);
        check("b2b rx_valid count", 64'(rxv_cnt[1] - rx0), 64'(2));
        check("b2b rx word0", 64'(rx_log[1][rx0 % 64]), 64'h11);
        check("b2b rx word1", 64'(rx_log[1][(rx0+1) % 64]), 64'h22);
        check("b2b underrun count", 64'(und_cnt[1] - und0), 64'(0));

        // Frame aborted after 5 bits: error pulse, previous word kept.
        load_tx(0, 8'h00);
        spi_frame(0, 8, 64'h6E, 1'b1, miso_v);
        repeat (4) @(posedge clk);
        #1;
        check("abort pre rx_data", 64'(rx_data[0]), 64'h6E);
        rx0 = rxv_cnt[0];
        fe0 = fe_cnt[0];
        spi_frame(0, 5, 64'h15, 1'b1, miso_v);
        repeat (4) @(posedge clk);
        #1;
        check("abort frame_err count", 64'(fe_cnt[0] - fe0), 64'(1));
        check("abort rx_valid count",  64'(rxv_cnt[0] - rx0), 64'(0));
        check("abort rx_data kept",    64'(rx_data[0]), 64'h6E);
        check("abort busy",            64'(busy[0]), 64'(0));

        // Reset in the middle of a word, then a clean frame.
        fe0 = fe_cnt[2];
        spi_frame(2, 4, 64'hA, 1'b0, miso_v);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #20;
        check("midrst busy",      64'(busy[2]),      64'(0));
        check("midrst miso",      64'(miso[2]),      64'(0));
        check("midrst miso_oe",   64'(miso_oe[2]),   64'(0));
        check("midrst tx_ready",  64'(tx_ready[2]),  64'(1));
        check("midrst rx_data",   64'(rx_data[2]),   64'(0));
        check("midrst rx_valid",  64'(rx_valid[2]),  64'(0));
        check("midrst underrun",  64'(underrun[2]),  64'(0));
        check("midrst frame_err", 64'(frame_err[2]), 64'(0));
        ss_n[2] = 1'b1;
        sclk[2] = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("midrst no frame_err", 64'(fe_cnt[2] - fe0), 64'(0));
        rx0 = rxv_cnt[2];
        load_tx(2, 8'h96);
        spi_frame(2, 8, 64'hC3, 1'b1, miso_v);
        repeat (4) @(posedge clk);
        #1;
        check("postrst rx_data",  64'(rx_data[2]), 64'hC3);
        check("postrst rx_valid count", 64'(rxv_cnt[2] - rx0), 64'(1));
        check("postrst miso",     64'(miso_v[7:0]), 64'h96);

        // Randomized frames against the word-level model.
        for (int it = 0; it < 16; it++) run_random(it);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
